// File: rtl/vga_grid_pkg.sv
// Shared types and constants for the sequencer step-grid painter.
package vga_grid_pkg;

  typedef enum logic [1:0] {
    KIND_OFF      = 2'd0,
    KIND_ON       = 2'd1,
    KIND_CURSOR   = 2'd2,
    KIND_PLAYHEAD = 2'd3
  } req_kind_e;

  typedef enum logic [1:0] {
    S_INIT_WAIT = 2'd0,
    S_INIT_FILL = 2'd1,
    S_IDLE      = 2'd2,
    S_CELL_FILL = 2'd3
  } state_e;

  typedef struct packed {
    logic [3:0] col;
    logic [3:0] row;
    req_kind_e  kind;
  } grid_req_t;

  localparam int REQ_W = $bits(grid_req_t);

  localparam logic [8:0] WHITE = 9'h1FF;
  localparam logic [8:0] BLUE  = 9'h007;
  localparam logic [8:0] RED   = 9'h1C0;
  localparam logic [8:0] GREEN = 9'h038;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  function automatic logic [8:0] kind_color(req_kind_e k);
    logic [8:0] c;
    unique case (k)
      KIND_OFF:      c = WHITE;
      KIND_ON:       c = BLUE;
      KIND_CURSOR:   c = RED;
      KIND_PLAYHEAD: c = GREEN;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/grid_req_fifo.sv
// Small synchronous FIFO holding pending cell redraw requests.
module grid_req_fifo #(
  parameter int W     = 10,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic         do_wr, do_rd;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;
  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q + (AW+1)'(do_wr);
    rd_ptr_d = rd_ptr_q + (AW+1)'(do_rd);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/vga_grid_renderer.sv
// Step-grid painter: initial white fill, then queued per-cell redraws,
// one pixel per clock towards the VGA adapter.
module vga_grid_renderer
  import vga_grid_pkg::*;
#(
  parameter int COLS        = 12,
  parameter int ROWS        = 12,
  parameter int CELL        = 31,
  parameter int PITCH       = 33,
  parameter int X0          = 214,
  parameter int Y0          = 32,
  parameter int BORDER      = 3,
  parameter int COLOR_DEPTH = 9,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                   CLOCK_50,
  input  logic                   Reset,
  input  logic                   vga_ready,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [3:0]             req_col,
  input  logic [3:0]             req_row,
  input  logic [1:0]             req_kind,
  output logic [9:0]             pix_x,
  output logic [8:0]             pix_y,
  output logic [COLOR_DEPTH-1:0] pix_color,
  output logic                   pix_write,
  output logic                   init_done,
  output logic                   busy,
  output logic                   req_err
);

  localparam int X_MAX = X0 + (COLS-1)*PITCH + CELL - 1;
  localparam int Y_MAX = Y0 + (ROWS-1)*PITCH + CELL - 1;

  if (X_MAX >= SCREEN_W || Y_MAX >= SCREEN_H) begin : g_geom_err
    $error("grid geometry exceeds the screen");
  end

  state_e    state_q, state_d;
  logic [5:0] dx_q, dx_d, dy_q, dy_d;
  logic [3:0] col_q, col_d, row_q, row_d;
  req_kind_e kind_q, kind_d;
  logic [9:0] pix_x_q, pix_x_d;
  logic [8:0] pix_y_q, pix_y_d;
  logic [COLOR_DEPTH-1:0] pix_color_q, pix_color_d;
  logic pix_write_q, pix_write_d;
  logic init_done_q, init_done_d;
  logic req_err_q, req_err_d;

  grid_req_t wr_req, head;
  logic fifo_full, fifo_empty, push, pop, load;
  logic last_dx, last_dy, last_pix, last_col, last_row, last_cell;
  logic head_ok, painting, on_border;
  logic [9:0] cur_x;
  logic [8:0] cur_y;

  assign wr_req = '{col: req_col, row: req_row,
                    kind: req_kind_e'(req_kind)};
  assign push = req_valid && !fifo_full;

  grid_req_fifo #(
    .W     (REQ_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (CLOCK_50),
    .rst     (Reset),
    .wr_en   (push),
    .wr_data (wr_req),
    .rd_en   (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign last_dx   = (dx_q == 6'(CELL-1));
  assign last_dy   = (dy_q == 6'(CELL-1));
  assign last_pix  = last_dx && last_dy;
  assign last_col  = (col_q == 4'(COLS-1));
  assign last_row  = (row_q == 4'(ROWS-1));
  assign last_cell = last_col && last_row;
  assign head_ok   = ({1'b0, head.col} < 5'(COLS)) &&
                     ({1'b0, head.row} < 5'(ROWS));
  assign painting  = (state_q == S_INIT_FILL) ||
                     (state_q == S_CELL_FILL);
  assign on_border = (dx_q < 6'(BORDER)) ||
                     (dx_q >= 6'(CELL-BORDER)) ||
                     (dy_q < 6'(BORDER)) ||
                     (dy_q >= 6'(CELL-BORDER));
  assign cur_x = 10'(X0) + 10'(col_q) * 10'(PITCH) + 10'(dx_q);
  assign cur_y = 9'(Y0) + 9'(row_q) * 9'(PITCH) + 9'(dy_q);

  always_ff @(posedge CLOCK_50 or posedge Reset) begin
    if (Reset) state_q <= S_INIT_WAIT;
    else       state_q <= state_d;
  end

  // Out-of-range entries are popped but never start a fill.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    load    = 1'b0;
    unique case (state_q)
      S_INIT_WAIT: if (vga_ready) state_d = S_INIT_FILL;
      S_INIT_FILL: if (last_pix && last_cell) state_d = S_IDLE;
      S_IDLE: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          if (head_ok) begin
            load    = 1'b1;
            state_d = S_CELL_FILL;
          end
        end
      end
      S_CELL_FILL: begin
        if (last_pix) begin
          state_d = S_IDLE;
          if (!fifo_empty) begin
            pop = 1'b1;
            if (head_ok) begin
              load    = 1'b1;
              state_d = S_CELL_FILL;
            end
          end
        end
      end
    endcase
  end

  always_comb begin
    dx_d        = dx_q;
    dy_d        = dy_q;
    col_d       = col_q;
    row_d       = row_q;
    kind_d      = kind_q;
    pix_x_d     = pix_x_q;
    pix_y_d     = pix_y_q;
    pix_color_d = pix_color_q;
    pix_write_d = 1'b0;
    init_done_d = init_done_q || (state_q == S_IDLE);
    req_err_d   = push && (({1'b0, req_col} >= 5'(COLS)) ||
                           ({1'b0, req_row} >= 5'(ROWS)));
    if (painting) begin
      pix_x_d = cur_x;
      pix_y_d = cur_y;
      if (state_q == S_INIT_FILL) begin
        pix_color_d = COLOR_DEPTH'(WHITE);
        pix_write_d = 1'b1;
      end else begin
        pix_color_d = COLOR_DEPTH'(kind_color(kind_q));
        pix_write_d = (kind_q != KIND_CURSOR) || on_border;
      end
      dx_d = last_dx ? 6'd0 : dx_q + 6'd1;
      if (last_dx) dy_d = last_dy ? 6'd0 : dy_q + 6'd1;
      if (state_q == S_INIT_FILL && last_pix) begin
        col_d = last_col ? 4'd0 : col_q + 4'd1;
        if (last_col) row_d = last_row ? 4'd0 : row_q + 4'd1;
      end
    end
    if (load) begin
      col_d  = head.col;
      row_d  = head.row;
      kind_d = head.kind;
      dx_d   = 6'd0;
      dy_d   = 6'd0;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge Reset) begin
    if (Reset) begin
      dx_q        <= '0;
      dy_q        <= '0;
      col_q       <= '0;
      row_q       <= '0;
      kind_q      <= KIND_OFF;
      pix_x_q     <= 10'(X0);
      pix_y_q     <= 9'(Y0);
      pix_color_q <= '0;
      pix_write_q <= 1'b0;
      init_done_q <= 1'b0;
      req_err_q   <= 1'b0;
    end else begin
      dx_q        <= dx_d;
      dy_q        <= dy_d;
      col_q       <= col_d;
      row_q       <= row_d;
      kind_q      <= kind_d;
      pix_x_q     <= pix_x_d;
      pix_y_q     <= pix_y_d;
      pix_color_q <= pix_color_d;
      pix_write_q <= pix_write_d;
      init_done_q <= init_done_d;
      req_err_q   <= req_err_d;
    end
  end

  assign pix_x     = pix_x_q;
  assign pix_y     = pix_y_q;
  assign pix_color = pix_color_q;
  assign pix_write = pix_write_q;
  assign init_done = init_done_q;
  assign req_err   = req_err_q;
  assign req_ready = !fifo_full;
  assign busy      = (state_q != S_IDLE) || !fifo_empty;

endmodule
